// File: rtl/booth_pkg.sv
// ============================================================================
//  booth_pkg : shared types and sizing helper for the sequential Booth multiplier
//  Revision  : 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold WIDTH+1 (the number of Booth steps per operation).
   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/booth_step.sv
// ============================================================================
//  booth_step : one combinational radix-2 Booth step (add/sub, then ASR by 1)
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module booth_step #(
   parameter int N = 9
) (
   input  logic [N-1:0] acc,
   input  logic [N-1:0] q,
   input  logic         q_m1,
   input  logic [N-1:0] m,
   output logic [N-1:0] acc_next,
   output logic [N-1:0] q_next,
   output logic         q_m1_next
);

   logic [N-1:0] sum;

   always_comb begin
      sum = acc;
      case ({q[0], q_m1})
         2'b01:   sum = acc + m;
         2'b10:   sum = acc - m;
         default: sum = acc;
      endcase
   end

   // Arithmetic shift of {A,Q,Q-1}: A's sign bit is replicated, Q[0] becomes Q-1.
   assign {acc_next, q_next, q_m1_next} = {sum[N-1], sum, q};

endmodule

`default_nettype wire

// File: rtl/booth_seq_mult.sv
// ============================================================================
//  booth_seq_mult : sequential radix-2 Booth multiplier, one step per cycle,
//                   signed/unsigned operands, start/done handshake
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sgn,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int            W1       = WIDTH + 1;
   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(W1);

   state_t             state;
   state_t             state_next;

   logic [W1-1:0]      acc;
   logic [W1-1:0]      q;
   logic               q_m1;
   logic [W1-1:0]      m;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod;

   logic [W1-1:0]      acc_step;
   logic [W1-1:0]      q_step;
   logic               q_m1_step;
   logic               accept;
   logic               last_step;

   assign accept    = start && ((state == IDLE) || (state == DONE));
   assign last_step = (state == RUN) && (cnt == CW'(1));

   booth_step #(
      .N         (W1)
   ) u_step (
      .acc       (acc),
      .q         (q),
      .q_m1      (q_m1),
      .m         (m),
      .acc_next  (acc_step),
      .q_next    (q_step),
      .q_m1_next (q_m1_step)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         q    <= '0;
         q_m1 <= 1'b0;
         m    <= '0;
         cnt  <= '0;
         prod <= '0;
      end else if (accept) begin
         // The extra top bit lets unsigned operands ride through signed Booth math.
         acc  <= '0;
         q    <= {sgn & b[WIDTH-1], b};
         q_m1 <= 1'b0;
         m    <= {sgn & a[WIDTH-1], a};
         cnt  <= CNT_LOAD;
      end else if (state == RUN) begin
         acc  <= acc_step;
         q    <= q_step;
         q_m1 <= q_m1_step;
         cnt  <= cnt - CW'(1);
         if (last_step) begin
            prod <= {acc_step[WIDTH-2:0], q_step};
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign p    = prod;

endmodule

`default_nettype wire
